// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared constants, types and helpers for reg_share_arbiter.
//
// Contents:
//   DEFAULT_N / DEFAULT_W  default requester count and data width
//   MAX_N / MAX_IW         largest supported requester count and its index width
//   pick_t                 result of a round-robin scan (found flag + winner index)
//   onehot(idx, n)         one-hot vector of idx, MAX_N bits wide (bits >= n are zero)
//   rr_pick(elig, ptr, n)  first eligible index scanning ptr, ptr+1, ... modulo n
package reg_arb_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 32;
    localparam int MAX_N     = 16;
    localparam int MAX_IW    = 4;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } pick_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IW-1:0] idx, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && int'(idx) == i) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // The loop bound is the fixed maximum so the scan unrolls to a constant
    // structure; positions at or beyond n are skipped.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] elig,
                                      input logic [MAX_IW-1:0] ptr,
                                      input int n);
        pick_t r;
        int    j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !r.found) begin
                j = (int'(ptr) + i) % n;
                if (elig[j]) begin
                    r.found = 1'b1;
                    r.idx   = MAX_IW'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// reg_share_arbiter_if: requester-side bus of the shared-register arbiter.
//
// Signals:
//   req   [N]    per-requester write request (level)
//   wdata [N*W]  packed write data, slice i = wdata[i*W +: W]
//   lock  [N]    owner lock request (only when REG_ARB_LOCK_EN is defined)
//   gnt   [N]    registered one-hot write acknowledge, one-cycle pulse
//   q     [W]    shared register contents
//   owner [IW]   index of the last requester written
//   valid        q has been written since reset
//
// Handshake: a requester raises req[i] with wdata slice i and holds both
// stable until it sees gnt[i]=1 (sampled after the edge that wrote q). It
// then drops req[i] or keeps it high for another write; a kept request is
// eligible again in the cycle after gnt[i] falls.
//
// Modports: master = requester side, slave = arbiter side.
// Optional macro: REG_ARB_LOCK_EN adds the lock signal.
interface reg_share_arbiter_if #(
    parameter int N = reg_arb_pkg::DEFAULT_N,
    parameter int W = reg_arb_pkg::DEFAULT_W
);
    localparam int IW = $clog2(N);

    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [IW-1:0]  owner;
    logic           valid;
`ifdef REG_ARB_LOCK_EN
    logic [N-1:0]   lock;

    modport master (output req, wdata, lock, input gnt, q, owner, valid);
    modport slave  (input req, wdata, lock, output gnt, q, owner, valid);
`else
    modport master (output req, wdata, input gnt, q, owner, valid);
    modport slave  (input req, wdata, output gnt, q, owner, valid);
`endif

endinterface

// File: rtl/reg_share_arbiter_rr_pick_ptr.sv
// rr_pick_ptr: round-robin pointer register plus the masked priority scan.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   eligible    requesters allowed to win this cycle
//   hold        keep the pointer where it is even if a winner is found
//   winner      first eligible index from ptr upwards, modulo N
//   found       some requester is eligible
//   ptr         current round-robin pointer (debug visibility)
module rr_pick_ptr
    import reg_arb_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  eligible,
    input  logic          hold,
    output logic [IW-1:0] winner,
    output logic          found,
    output logic [IW-1:0] ptr
);

    logic [IW-1:0] ptr_q, ptr_d;
    pick_t         pick;

    always_comb begin
        pick   = rr_pick(MAX_N'(eligible), MAX_IW'(ptr_q), N);
        winner = IW'(pick.idx);
        found  = pick.found;
    end

    // The pointer moves to just past the winner so the winner has lowest
    // priority on the next scan.
    always_comb begin
        ptr_d = ptr_q;
        if (found && !hold) begin
            ptr_d = (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin sharing of one W-bit register among N
// requesters. Each cycle at most one requester is written into q and gets
// a one-cycle registered gnt pulse as acknowledge.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         reg_share_arbiter_if.slave (req, wdata, [lock], gnt, q, owner, valid)
//   dbg_ptr     current round-robin pointer
//
// Optional macro: REG_ARB_LOCK_EN. When defined, an owner holding both
// req[owner] and lock[owner] (with valid=1) keeps winning back-to-back,
// bypassing its gnt mask, and the pointer is frozen until the lock drops.
module reg_share_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int IW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_share_arbiter_if.slave   bus,
    output logic [IW-1:0]        dbg_ptr
);

    logic [W-1:0]  q_q, q_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          valid_q, valid_d;

    logic [N-1:0]  eligible;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          lock_hit;
    logic [IW-1:0] sel_idx;
    logic          write;

    // A requester acknowledged this cycle is masked so a held request is
    // not written twice for one handshake.
    assign eligible = bus.req & ~gnt_q;

`ifdef REG_ARB_LOCK_EN
    assign lock_hit = valid_q & bus.req[owner_q] & bus.lock[owner_q];
`else
    assign lock_hit = 1'b0;
`endif

    rr_pick_ptr #(.N(N), .IW(IW)) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .hold     (lock_hit),
        .winner   (pick_idx),
        .found    (pick_found),
        .ptr      (dbg_ptr)
    );

    always_comb begin
        sel_idx = lock_hit ? owner_q : pick_idx;
        write   = lock_hit | pick_found;

        q_d     = q_q;
        owner_d = owner_q;
        valid_d = valid_q;
        gnt_d   = '0;
        if (write) begin
            q_d     = bus.wdata[int'(sel_idx)*W +: W];
            owner_d = sel_idx;
            valid_d = 1'b1;
            gnt_d   = N'(onehot(MAX_IW'(sel_idx), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end

    assign bus.q     = q_q;
    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb_reg_share_arbiter: directed vector table plus hand-written sequences
// for asynchronous reset, full contention and (with REG_ARB_LOCK_EN) lock.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] dbg_ptr;

    reg_share_arbiter_if #(.N(N), .W(W)) bus ();

    reg_share_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dbg_ptr (dbg_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] wdata;
        logic [N-1:0]   exp_gnt;
        logic [W-1:0]   exp_q;
        logic [IW-1:0]  exp_owner;
        logic           exp_valid;
        logic [IW-1:0]  exp_ptr;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [N*W-1:0] mk_wd(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                             input logic [W-1:0] s2, input logic [W-1:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] g, input logic [W-1:0] qv,
                              input logic [IW-1:0] ow, input logic vl);
        check({tag, "_gnt"},   W'(bus.gnt),   W'(g));
        check({tag, "_q"},     bus.q,         qv);
        check({tag, "_owner"}, W'(bus.owner), W'(ow));
        check({tag, "_valid"}, W'(bus.valid), W'(vl));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.req   = '0;
        bus.wdata = '0;
`ifdef REG_ARB_LOCK_EN
        bus.lock  = '0;
`endif

        //            req      wdata                                        gnt      q             own  vld  ptr
        vecs[0]  = '{4'b0000, mk_wd(0, 0, 0, 0),                             4'b0000, 32'h0,        2'd0, 1'b0, 2'd0};
        vecs[1]  = '{4'b0100, mk_wd(0, 0, 32'hDEADBEEF, 0),                  4'b0100, 32'hDEADBEEF, 2'd2, 1'b1, 2'd3};
        vecs[2]  = '{4'b0000, mk_wd(0, 0, 32'h55, 0),                        4'b0000, 32'hDEADBEEF, 2'd2, 1'b1, 2'd3};
        vecs[3]  = '{4'b1001, mk_wd(32'hA0, 0, 0, 32'hA3),                   4'b1000, 32'hA3,       2'd3, 1'b1, 2'd0};
        vecs[4]  = '{4'b0001, mk_wd(32'hA0, 0, 0, 32'hA3),                   4'b0001, 32'hA0,       2'd0, 1'b1, 2'd1};
        vecs[5]  = '{4'b0000, mk_wd(32'hA0, 0, 0, 0),                        4'b0000, 32'hA0,       2'd0, 1'b1, 2'd1};
        vecs[6]  = '{4'b0001, mk_wd(32'hB0, 0, 0, 0),                        4'b0001, 32'hB0,       2'd0, 1'b1, 2'd1};
        vecs[7]  = '{4'b0001, mk_wd(32'hB0, 0, 0, 0),                        4'b0000, 32'hB0,       2'd0, 1'b1, 2'd1};
        vecs[8]  = '{4'b0001, mk_wd(32'hB1, 0, 0, 0),                        4'b0001, 32'hB1,       2'd0, 1'b1, 2'd1};
        vecs[9]  = '{4'b0001, mk_wd(32'hB1, 0, 0, 0),                        4'b0000, 32'hB1,       2'd0, 1'b1, 2'd1};
        vecs[10] = '{4'b0110, mk_wd(0, 32'hC1, 32'hC2, 0),                   4'b0010, 32'hC1,       2'd1, 1'b1, 2'd2};
        vecs[11] = '{4'b0110, mk_wd(0, 32'hC1, 32'hC2, 0),                   4'b0100, 32'hC2,       2'd2, 1'b1, 2'd3};
        vecs[12] = '{4'b0110, mk_wd(0, 32'hC1, 32'hC2, 0),                   4'b0010, 32'hC1,       2'd1, 1'b1, 2'd2};

        do_reset();
        @(negedge clk);
        check_outs("reset", 4'b0000, 32'h0, 2'd0, 1'b0);
        check("reset_ptr", W'(dbg_ptr), 32'd0);

        // vector table
        for (int i = 0; i < 13; i++) begin
            bus.req   = vecs[i].req;
            bus.wdata = vecs[i].wdata;
            tick();
            check_outs($sformatf("v%0d", i), vecs[i].exp_gnt, vecs[i].exp_q,
                       vecs[i].exp_owner, vecs[i].exp_valid);
            check($sformatf("v%0d_ptr", i), W'(dbg_ptr), W'(vecs[i].exp_ptr));
        end

        // asynchronous reset mid-cycle with all requests high
        bus.req = 4'b1111;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("arst", 4'b0000, 32'h0, 2'd0, 1'b0);
        check("arst_ptr", W'(dbg_ptr), 32'd0);
        @(posedge clk);
        #1;
        check_outs("arst_hold", 4'b0000, 32'h0, 2'd0, 1'b0);

        // full contention from reset: grant order 0,1,2,3,0
        @(negedge clk);
        bus.wdata = mk_wd(32'h10, 32'h11, 32'h12, 32'h13);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_outs($sformatf("cont%0d", k), 4'(1 << (k % 4)), 32'h10 + W'(k % 4),
                       IW'(k % 4), 1'b1);
        end
        bus.req = '0;
        tick();
        check_outs("cont_idle", 4'b0000, 32'h10, 2'd0, 1'b1);

`ifdef REG_ARB_LOCK_EN
        // lock: owner 1 keeps winning for 3 consecutive cycles, then 2 is next
        do_reset();
        bus.req   = 4'b1111;
        bus.lock  = 4'b0010;
        bus.wdata = mk_wd(32'h20, 32'h21, 32'h22, 32'h23);
        tick();
        check_outs("lk0", 4'b0001, 32'h20, 2'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outs($sformatf("lk_hold%0d", k), 4'b0010, 32'h21, 2'd1, 1'b1);
            check($sformatf("lk_hold%0d_ptr", k), W'(dbg_ptr), 32'd2);
        end
        bus.lock = '0;
        tick();
        check_outs("lk_rel", 4'b0100, 32'h22, 2'd2, 1'b1);
        bus.req = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
